alu_result_fifo: RTL and testbench

//  Downstream capture stage for the 8-bit ALU. Each ALU result beat carries y[7:0], the op

---
 rtl/alu_result_fifo.sv | 160 ++++++++++++++++
 tb/tb_alu_result_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Purpose : capture FIFO for 8-bit ALU result beats with flag checking and status counters.
// Latency : a beat accepted on edge N appears on out_* after edge N; no input-to-output path.
// Backpr. : in_ready is a registered !full; in_valid is ignored while full, the head holds until out_ready.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          input handshake; in_op, in_y, in_flags = {parity, overflow, greater, less, is_eq}
//   out_valid/out_ready        output handshake; out_data = {op, flags, y} of head (0 when empty)
//   out_err                    head entry failed the flag/parity check
//   level                      occupancy, 0..DEPTH
//   ovf_sticky, ovf_cnt        overflow seen / saturating overflow count
//   err_cnt                    saturating count of beats that failed the check
//   clr_stat                   synchronous clear of ovf_sticky, ovf_cnt, err_cnt
module alu_result_fifo #(
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 8,
   parameter int PAR_CHK = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_op,
   input  logic [7:0]               in_y,
   input  logic [4:0]               in_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [14:0]              out_data,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf_sticky,
   input  logic                     clr_stat,
   output logic [CNT_W-1:0]         ovf_cnt,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef struct packed {
      logic       err;
      logic [1:0] op;
      logic [4:0] flags;
      logic [7:0] y;
   } entry_t;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_HEAD  = 1'b1
   } head_state_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level_q;
   logic [LW-1:0]   level_nxt;
   logic            in_ready_q;
   head_state_t     state_q;
   head_state_t     state_nxt;
   entry_t          head;
   logic            push;
   logic            pop;
   logic            chk_fail;
   logic            beat_err;
   logic            beat_ovf;

   assign push     = in_valid & in_ready_q;
   assign pop      = out_valid & out_ready;
   assign beat_ovf = in_flags[3];

   // Exactly one of greater/less/is_eq must be set, and the parity bit must match the data.
   assign chk_fail = (in_flags[4] != ^in_y)
                   | (in_flags[2] & in_flags[1])
                   | (in_flags[0] & (in_flags[2] | in_flags[1]))
                   | ~(in_flags[2] | in_flags[1] | in_flags[0]);
   assign beat_err = (PAR_CHK != 0) & chk_fail;

   // Occupancy: full blocks push, so push+pop never happens at the boundaries.
   always_comb begin
      level_nxt = level_q;
      case ({push, pop})
         2'b10:   level_nxt = level_q + LVL_ONE;
         2'b01:   level_nxt = level_q - LVL_ONE;
         default: level_nxt = level_q;
      endcase
   end

   // Head-state FSM: tracks whether the head entry is presentable.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_EMPTY: if (push) state_nxt = S_HEAD;
         S_HEAD:  if (pop && (level_q == LVL_ONE) && !push) state_nxt = S_EMPTY;
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         in_ready_q <= 1'b1;
         state_q    <= S_EMPTY;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         level_q    <= level_nxt;
         in_ready_q <= (level_nxt != FULL_LVL);
         state_q    <= state_nxt;
      end
   end

   // Storage needs no reset: nothing reads it while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{err: beat_err, op: in_op, flags: in_flags, y: in_y};
      end
   end

   // Status counters; clr_stat wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         ovf_cnt    <= '0;
         err_cnt    <= '0;
      end else if (clr_stat) begin
         ovf_sticky <= 1'b0;
         ovf_cnt    <= '0;
         err_cnt    <= '0;
      end else if (push) begin
         if (beat_ovf) begin
            ovf_sticky <= 1'b1;
            if (ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + CNT_ONE;
         end
         if (beat_err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_ONE;
      end
   end

   // Head presentation: storage contents are undefined after reset, so gate with out_valid.
   always_comb begin
      head      = mem[rd_ptr];
      out_valid = (state_q == S_HEAD);
      out_data  = '0;
      out_err   = 1'b0;
      if (out_valid) begin
         out_data = {head.op, head.flags, head.y};
         out_err  = head.err;
      end
   end

   assign in_ready = in_ready_q;
   assign level    = level_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [7:0]  in_y;
   logic [4:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] out_data;
   logic        out_err;
   logic [2:0]  level;
   logic        ovf_sticky;
   logic        clr_stat;
   logic [7:0]  ovf_cnt;
   logic [7:0]  err_cnt;

   int cmp_cnt = 0;
   int mis_cnt = 0;

   alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PAR_CHK(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_y(in_y), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .level(level), .ovf_sticky(ovf_sticky), .clr_stat(clr_stat),
      .ovf_cnt(ovf_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of beats plus plain integer counters.
   typedef struct {
      logic [1:0] op;
      logic [4:0] fl;
      logic [7:0] y;
      logic       err;
   } beat_t;

   beat_t mq[$];
   int    m_ovf;
   int    m_err;
   logic  m_sticky;

   // A beat is bad when the parity bit disagrees with the ones-count of y,
   // or when the number of asserted relation flags is not exactly one.
   function automatic logic model_err(logic [7:0] y, logic [4:0] fl);
      int rel_cnt;
      logic odd;
      rel_cnt = int'(fl[2]) + int'(fl[1]) + int'(fl[0]);
      odd     = ($countones(y) % 2) == 1;
      return (fl[4] != odd) || (rel_cnt != 1);
   endfunction

   function automatic logic [14:0] model_head();
      if (mq.size() == 0) return 15'h0;
      return {mq[0].op, mq[0].fl, mq[0].y};
   endfunction

   function automatic logic [4:0] good_flags(logic [7:0] y, logic ovf);
      logic [2:0] rel;
      rel = 3'b001 << $urandom_range(0, 2);
      return {^y, ovf, rel};
   endfunction

   // Drive one cycle of stimulus, advance the model, and settle 1 ns after the edge.
   task automatic step(input logic v, input logic [1:0] op, input logic [7:0] y,
                       input logic [4:0] fl, input logic rdy, input logic clr);
      logic push_m;
      logic pop_m;
      beat_t b;
      in_valid  = v;
      in_op     = op;
      in_y      = y;
      in_flags  = fl;
      out_ready = rdy;
      clr_stat  = clr;
      push_m = v && (mq.size() < DEPTH);
      pop_m  = rdy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
         b.op = op; b.fl = fl; b.y = y; b.err = model_err(y, fl);
         mq.push_back(b);
      end
      if (clr) begin
         m_ovf = 0; m_err = 0; m_sticky = 1'b0;
      end else if (push_m) begin
         if (fl[3]) begin
            m_sticky = 1'b1;
            if (m_ovf < CMAX) m_ovf++;
         end
         if (model_err(y, fl) && m_err < CMAX) m_err++;
      end
      in_valid = 1'b0;
      clr_stat = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 0; in_op = 0; in_y = 0; in_flags = 0; out_ready = 0; clr_stat = 0;
      mq.delete(); m_ovf = 0; m_err = 0; m_sticky = 0;
      repeat (2) @(posedge clk);
      #1;
      cmp_cnt++;
      if ({in_ready, out_valid, level, out_data, out_err, ovf_sticky, ovf_cnt, err_cnt}
          !== {1'b1, 1'b0, 3'd0, 15'h0, 1'b0, 1'b0, 8'd0, 8'd0}) begin
         mis_cnt++;
         $display("FAIL reset_state: got rdy=%b vld=%b lvl=%0d dat=%h err=%b stk=%b ovf=%0d errc=%0d, want rdy=1 vld=0 lvl=0 dat=0 err=0 stk=0 ovf=0 errc=0",
                  in_ready, out_valid, level, out_data, out_err, ovf_sticky, ovf_cnt, err_cnt);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_first_beat();
      step(1'b1, 2'd0, 8'h3C, 5'b00001, 1'b0, 1'b0);
      cmp_cnt++;
      // {op=0, flags=00001, y=3C} packs to 15'h013C
      if ({out_valid, out_data, out_err, level} !== {1'b1, 15'h013C, 1'b0, 3'd1}) begin
         mis_cnt++;
         $display("FAIL first_beat: got vld=%b dat=%h err=%b lvl=%0d, want vld=1 dat=013c err=0 lvl=1",
                  out_valid, out_data, out_err, level);
      end
      step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
      cmp_cnt++;
      if ({out_valid, level, out_data} !== {1'b0, 3'd0, 15'h0}) begin
         mis_cnt++;
         $display("FAIL first_drain: got vld=%b lvl=%0d dat=%h, want vld=0 lvl=0 dat=0", out_valid, level, out_data);
      end
   endtask

   task automatic test_full();
      logic [7:0] y;
      for (int i = 0; i < DEPTH; i++) begin
         y = 8'($urandom);
         step(1'b1, 2'($urandom), y, good_flags(y, 1'b0), 1'b0, 1'b0);
         cmp_cnt++;
         if ({level, in_ready} !== {3'(i + 1), (i + 1) < DEPTH}) begin
            mis_cnt++;
            $display("FAIL fill_%0d: got lvl=%0d rdy=%b, want lvl=%0d rdy=%b", i, level, in_ready, i + 1, (i + 1) < DEPTH);
         end
      end
      step(1'b1, 2'd3, 8'hEE, good_flags(8'hEE, 1'b0), 1'b0, 1'b0);
      cmp_cnt++;
      if ({level, in_ready} !== {3'd4, 1'b0}) begin
         mis_cnt++;
         $display("FAIL full_drop: got lvl=%0d rdy=%b, want lvl=4 rdy=0", level, in_ready);
      end
      for (int i = 0; i < DEPTH; i++) begin
         cmp_cnt++;
         if (out_data !== model_head()) begin
            mis_cnt++;
            $display("FAIL drain_order_%0d: got %h, want %h", i, out_data, model_head());
         end
         step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
      end
      cmp_cnt++;
      if ({out_valid, level, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
         mis_cnt++;
         $display("FAIL drain_empty: got vld=%b lvl=%0d rdy=%b, want vld=0 lvl=0 rdy=1", out_valid, level, in_ready);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] y;
      for (int i = 0; i < 2; i++) begin
         y = 8'($urandom);
         step(1'b1, 2'($urandom), y, good_flags(y, 1'b0), 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         y = 8'($urandom);
         step(1'b1, 2'($urandom), y, good_flags(y, 1'b0), 1'b1, 1'b0);
         cmp_cnt++;
         if ({level, out_data} !== {3'd2, model_head()}) begin
            mis_cnt++;
            $display("FAIL wrap_%0d: got lvl=%0d dat=%h, want lvl=2 dat=%h", i, level, out_data, model_head());
         end
      end
      for (int i = 0; i < 2; i++) begin
         cmp_cnt++;
         if (out_data !== model_head()) begin
            mis_cnt++;
            $display("FAIL wrap_drain_%0d: got %h, want %h", i, out_data, model_head());
         end
         step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_err();
      step(1'b1, 2'd1, 8'h01, 5'b00001, 1'b0, 1'b0);
      cmp_cnt++;
      if ({out_err, err_cnt} !== {1'b1, 8'(m_err)} || m_err != 1) begin
         mis_cnt++;
         $display("FAIL parity_err: got err=%b errc=%0d, want err=1 errc=%0d", out_err, err_cnt, m_err);
      end
      step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
      step(1'b1, 2'd2, 8'h03, 5'b00110, 1'b0, 1'b0);
      cmp_cnt++;
      if ({out_err, err_cnt} !== {1'b1, 8'(m_err)} || m_err != 2) begin
         mis_cnt++;
         $display("FAIL gt_lt_err: got err=%b errc=%0d, want err=1 errc=%0d", out_err, err_cnt, m_err);
      end
      step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
   endtask

   task automatic test_ovf_sat();
      logic [7:0] y;
      step(1'b0, 2'd0, 8'h00, 5'b0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         y = 8'($urandom);
         step(1'b1, 2'($urandom), y, good_flags(y, 1'b1), 1'b1, 1'b0);
         if (i == 253 || i == 254 || i == 299) begin
            cmp_cnt++;
            if ({ovf_cnt, ovf_sticky} !== {8'(m_ovf), 1'b1}) begin
               mis_cnt++;
               $display("FAIL ovf_sat_%0d: got cnt=%0d stk=%b, want cnt=%0d stk=1", i, ovf_cnt, ovf_sticky, m_ovf);
            end
         end
      end
      cmp_cnt++;
      if (ovf_cnt !== 8'd255) begin
         mis_cnt++;
         $display("FAIL ovf_cap: got %0d, want 255", ovf_cnt);
      end
      y = 8'h5A;
      step(1'b1, 2'd0, y, good_flags(y, 1'b1), 1'b1, 1'b1);
      cmp_cnt++;
      if ({ovf_cnt, ovf_sticky, err_cnt} !== {8'd0, 1'b0, 8'd0}) begin
         mis_cnt++;
         $display("FAIL clr_prio: got cnt=%0d stk=%b errc=%0d, want 0 0 0", ovf_cnt, ovf_sticky, err_cnt);
      end
      cmp_cnt++;
      if ({level, out_data} !== {3'(mq.size()), model_head()}) begin
         mis_cnt++;
         $display("FAIL clr_fifo: got lvl=%0d dat=%h, want lvl=%0d dat=%h", level, out_data, mq.size(), model_head());
      end
      step(1'b1, 2'd0, y, good_flags(y, 1'b1), 1'b1, 1'b0);
      cmp_cnt++;
      if ({ovf_cnt, ovf_sticky} !== {8'd1, 1'b1}) begin
         mis_cnt++;
         $display("FAIL ovf_after_clr: got cnt=%0d stk=%b, want 1 1", ovf_cnt, ovf_sticky);
      end
      step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [7:0] y;
      for (int i = 0; i < 3; i++) begin
         y = 8'($urandom);
         step(1'b1, 2'($urandom), y, good_flags(y, 1'b0), 1'b0, 1'b0);
      end
      cmp_cnt++;
      if (level !== 3'd3) begin
         mis_cnt++;
         $display("FAIL pre_reset_level: got %0d, want 3", level);
      end
      #2 rst_n = 1'b0;
      #1;
      mq.delete(); m_ovf = 0; m_err = 0; m_sticky = 0;
      cmp_cnt++;
      if ({out_valid, level, ovf_cnt, err_cnt, ovf_sticky, in_ready, out_data}
          !== {1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b1, 15'h0}) begin
         mis_cnt++;
         $display("FAIL async_reset: got vld=%b lvl=%0d ovf=%0d errc=%0d stk=%b rdy=%b dat=%h, want 0 0 0 0 0 1 0",
                  out_valid, level, ovf_cnt, err_cnt, ovf_sticky, in_ready, out_data);
      end
      @(posedge clk);
      #4 rst_n = 1'b1;
      y = 8'hA7;
      step(1'b1, 2'd2, y, good_flags(y, 1'b0), 1'b0, 1'b0);
      cmp_cnt++;
      if ({out_valid, level, out_data, out_err} !== {1'b1, 3'd1, model_head(), 1'b0}) begin
         mis_cnt++;
         $display("FAIL post_reset_push: got vld=%b lvl=%0d dat=%h err=%b, want 1 1 %h 0",
                  out_valid, level, out_data, out_err, model_head());
      end
      step(1'b0, 2'd0, 8'h00, 5'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [37:0] got;
      logic [37:0] exp;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 2'($urandom), 8'($urandom), 5'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0));
         got = {in_ready, out_valid, level, out_data, out_err, ovf_sticky, ovf_cnt, err_cnt};
         exp = {mq.size() < DEPTH, mq.size() > 0, 3'(mq.size()), model_head(),
                (mq.size() > 0) ? mq[0].err : 1'b0, m_sticky, 8'(m_ovf), 8'(m_err)};
         cmp_cnt++;
         if (got !== exp) begin
            mis_cnt++;
            $display("FAIL random_%0d: got %h, want %h (rdy,vld,lvl,dat,err,stk,ovf,errc)", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_beat();
      test_full();
      test_wrap();
      test_err();
      test_ovf_sat();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
